// File: rtl/axi_uart_pkg.sv
// Shared constants and FSM state type for the UART-to-AXI-Lite debug bridge.
package axi_uart_pkg;

    localparam logic [7:0] CMD_WRITE    = 8'h57;
    localparam logic [7:0] CMD_READ     = 8'h52;
    localparam logic [7:0] STAT_TIMEOUT = 8'h04;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_AW_W,
        S_B,
        S_AR,
        S_R,
        S_RESP
    } state_t;

endpackage

// File: rtl/axi_uart_resp_ser.sv
// Response serialiser: status byte then up to four data bytes (LSB first) on a byte stream.
module axi_uart_resp_ser (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [7:0]  stat,
    input  logic [31:0] data,
    input  logic [2:0]  len,
    output logic [7:0]  m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        done
);
    logic [31:0] rest;
    logic [2:0]  idx;
    logic [2:0]  last;

    assign done = m_axis_tvalid && m_axis_tready && (idx == last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_axis_tdata  <= 8'h00;
            m_axis_tvalid <= 1'b0;
            rest          <= 32'h0;
            idx           <= 3'd0;
            last          <= 3'd0;
        end else if (load) begin
            m_axis_tdata  <= stat;
            m_axis_tvalid <= 1'b1;
            rest          <= data;
            idx           <= 3'd0;
            last          <= len - 3'd1;
        end else if (m_axis_tvalid && m_axis_tready) begin
            if (idx == last) begin
                m_axis_tvalid <= 1'b0;
            end else begin
                m_axis_tdata <= rest[7:0];
                rest         <= {8'h00, rest[31:8]};
                idx          <= idx + 3'd1;
            end
        end
    end

endmodule

// File: rtl/axi_lite_uart_master.sv
// UART byte-stream command parser issuing single AXI-Lite reads/writes.
// Optional response timeout compiled in with AXI_UART_MASTER_TIMEOUT_EN.
module axi_lite_uart_master
    import axi_uart_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    output logic [7:0]  m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic [31:0] awaddr,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wvalid,
    input  logic        wready,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready,
    output logic [31:0] araddr,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rvalid,
    output logic        rready
);
    state_t      state;
    logic        is_read;
    logic [1:0]  byte_cnt;
    logic [31:0] sr;
    logic [31:0] sr_next;
    logic        resp_load;
    logic [7:0]  resp_stat;
    logic [31:0] resp_data;
    logic [2:0]  resp_len;
    logic        resp_done;
    logic        aw_done;
    logic        w_done;
    logic        tmo_hit;

    assign s_axis_tready = (state == S_IDLE) || (state == S_ADDR) || (state == S_DATA);
    assign sr_next       = {s_axis_tdata, sr[31:8]};
    assign aw_done       = !awvalid || awready;
    assign w_done        = !wvalid || wready;
    assign wstrb         = 4'hF;

`ifdef AXI_UART_MASTER_TIMEOUT_EN
    logic [31:0] tmo_cnt;

    // Counter is held at zero while parsing, so it starts fresh on entry to AW_W/AR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)             tmo_cnt <= 32'd0;
        else if (s_axis_tready) tmo_cnt <= 32'd0;
        else if (state != S_RESP) tmo_cnt <= tmo_cnt + 32'd1;
    end

    assign tmo_hit = (state inside {S_AW_W, S_B, S_AR, S_R}) &&
                     (tmo_cnt == 32'(TIMEOUT_CYCLES - 1));
`else
    logic unused_tmo;
    assign unused_tmo = ^TIMEOUT_CYCLES;
    assign tmo_hit    = 1'b0;
`endif

    // Response capture is combinational so the serialiser latches on the handshake edge.
    always_comb begin
        resp_load = 1'b0;
        resp_stat = 8'h00;
        resp_data = 32'h0;
        resp_len  = 3'd1;
        if (state == S_B && bvalid && bready) begin
            resp_load = 1'b1;
            resp_stat = {6'b0, bresp};
        end else if (state == S_R && rvalid && rready) begin
            resp_load = 1'b1;
            resp_stat = {6'b0, rresp};
            resp_data = rdata;
            resp_len  = 3'd5;
        end
        if (tmo_hit) begin
            resp_load = 1'b1;
            resp_stat = STAT_TIMEOUT;
            resp_data = 32'h0;
            resp_len  = is_read ? 3'd5 : 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            is_read  <= 1'b0;
            byte_cnt <= 2'd0;
            sr       <= 32'h0;
            awaddr   <= 32'h0;
            araddr   <= 32'h0;
            wdata    <= 32'h0;
            awvalid  <= 1'b0;
            wvalid   <= 1'b0;
            bready   <= 1'b0;
            arvalid  <= 1'b0;
            rready   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (s_axis_tvalid) begin
                    byte_cnt <= 2'd0;
                    if (s_axis_tdata == CMD_WRITE) begin
                        is_read <= 1'b0;
                        state   <= S_ADDR;
                    end else if (s_axis_tdata == CMD_READ) begin
                        is_read <= 1'b1;
                        state   <= S_ADDR;
                    end
                end
                S_ADDR: if (s_axis_tvalid) begin
                    sr       <= sr_next;
                    byte_cnt <= byte_cnt + 2'd1;
                    if (byte_cnt == 2'd3) begin
                        if (is_read) begin
                            araddr  <= sr_next;
                            arvalid <= 1'b1;
                            state   <= S_AR;
                        end else begin
                            awaddr <= sr_next;
                            state  <= S_DATA;
                        end
                    end
                end
                S_DATA: if (s_axis_tvalid) begin
                    sr       <= sr_next;
                    byte_cnt <= byte_cnt + 2'd1;
                    if (byte_cnt == 2'd3) begin
                        wdata   <= sr_next;
                        awvalid <= 1'b1;
                        wvalid  <= 1'b1;
                        state   <= S_AW_W;
                    end
                end
                S_AW_W: begin
                    if (awready) awvalid <= 1'b0;
                    if (wready)  wvalid  <= 1'b0;
                    if (aw_done && w_done) begin
                        bready <= 1'b1;
                        state  <= S_B;
                    end
                end
                S_B: if (bvalid) begin
                    bready <= 1'b0;
                    state  <= S_RESP;
                end
                S_AR: if (arready) begin
                    arvalid <= 1'b0;
                    rready  <= 1'b1;
                    state   <= S_R;
                end
                S_R: if (rvalid) begin
                    rready <= 1'b0;
                    state  <= S_RESP;
                end
                S_RESP: if (resp_done) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
            // Abandoning the AXI handshake on timeout is intentional for a debug bridge.
            if (tmo_hit) begin
                awvalid <= 1'b0;
                wvalid  <= 1'b0;
                bready  <= 1'b0;
                arvalid <= 1'b0;
                rready  <= 1'b0;
                state   <= S_RESP;
            end
        end
    end

    axi_uart_resp_ser u_ser (
        .clk           (clk),
        .rst_n         (rst_n),
        .load          (resp_load),
        .stat          (resp_stat),
        .data          (resp_data),
        .len           (resp_len),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .done          (resp_done)
    );

endmodule

// File: tb/tb_axi_lite_uart_master.sv
// Directed bench for axi_lite_uart_master; timeout scenario runs when AXI_UART_MASTER_TIMEOUT_EN is defined.
module tb_axi_lite_uart_master;
`ifdef AXI_UART_MASTER_TIMEOUT_EN
    localparam int TCY = 16;
`else
    localparam int TCY = 1024;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  s_tdata;
    logic        s_tvalid;
    logic        s_tready;
    logic [7:0]  m_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    axi_lite_uart_master #(.TIMEOUT_CYCLES(TCY)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
        .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Drives bytes back to back from a negedge; no AXI request may appear mid-frame.
    task automatic send(input logic [7:0] b [], input string tag);
        foreach (b[i]) begin
            chk({tag, " s_tready"}, 32'(s_tready), 32'd1);
            chk({tag, " quiet"}, 32'(awvalid | wvalid | arvalid), 32'd0);
            s_tvalid = 1'b1;
            s_tdata  = b[i];
            @(negedge clk);
        end
        s_tvalid = 1'b0;
    endtask

    // Zero-wait write of 0xDEADBEEF to 0x40000010, cycle-exact checks.
    task automatic zero_wait_write(input string tag);
        awready = 1'b1; wready = 1'b1; bvalid = 1'b1; bresp = 2'd0; m_tready = 1'b1;
        send('{8'h57, 8'h10, 8'h00, 8'h00, 8'h40, 8'hEF, 8'hBE, 8'hAD, 8'hDE}, tag);
        chk({tag, " awvalid"}, 32'(awvalid), 32'd1);
        chk({tag, " wvalid"},  32'(wvalid),  32'd1);
        chk({tag, " awaddr"},  awaddr, 32'h4000_0010);
        chk({tag, " wdata"},   wdata,  32'hDEAD_BEEF);
        chk({tag, " wstrb"},   32'(wstrb), 32'hF);
        @(negedge clk);
        chk({tag, " aw dropped"}, 32'(awvalid | wvalid), 32'd0);
        chk({tag, " bready"},     32'(bready), 32'd1);
        @(negedge clk);
        chk({tag, " resp valid"}, 32'(m_tvalid), 32'd1);
        chk({tag, " resp byte"},  32'(m_tdata), 32'h00);
        chk({tag, " bready low"}, 32'(bready), 32'd0);
        @(negedge clk);
        chk({tag, " resp end"}, 32'(m_tvalid), 32'd0);
        chk({tag, " idle"},     32'(s_tready), 32'd1);
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
    endtask

    initial begin
        logic [7:0] exp_b [5];
        int idx;
        int n;
        logic prev_rdy;
        logic [3:0] pat;

        rst_n = 1'b0; s_tdata = 8'h00; s_tvalid = 1'b0; m_tready = 1'b0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'd0;
        arready = 1'b0; rvalid = 1'b0; rresp = 2'd0; rdata = 32'h0;
        @(negedge clk);
        chk("rst valids", 32'({awvalid, wvalid, arvalid, bready, rready, m_tvalid}), 32'd0);
        chk("rst awaddr", awaddr, 32'h0);
        chk("rst araddr", araddr, 32'h0);
        chk("rst wdata",  wdata,  32'h0);
        chk("rst tdata",  32'(m_tdata), 32'h0);
        chk("rst wstrb",  32'(wstrb), 32'hF);
        rst_n = 1'b1;
        @(negedge clk);

        zero_wait_write("wr0");

        // Read with 3 wait cycles on R, rresp=2.
        arready = 1'b1; m_tready = 1'b1;
        send('{8'h52, 8'h04, 8'h00, 8'h00, 8'h40}, "rd");
        chk("rd arvalid", 32'(arvalid), 32'd1);
        chk("rd araddr",  araddr, 32'h4000_0004);
        @(negedge clk);
        arready = 1'b0;
        chk("rd ar drop", 32'(arvalid), 32'd0);
        chk("rd rready",  32'(rready), 32'd1);
        repeat (3) begin
            @(negedge clk);
            chk("rd rready hold", 32'(rready), 32'd1);
        end
        rvalid = 1'b1; rdata = 32'h1234_5678; rresp = 2'd2;
        @(negedge clk);
        rvalid = 1'b0;
        chk("rd rready low", 32'(rready), 32'd0);
        exp_b = '{8'h02, 8'h78, 8'h56, 8'h34, 8'h12};
        for (int i = 0; i < 5; i++) begin
            chk("rd byte valid", 32'(m_tvalid), 32'd1);
            chk("rd byte", 32'(m_tdata), 32'(exp_b[i]));
            @(negedge clk);
        end
        chk("rd resp end", 32'(m_tvalid), 32'd0);

        // Write with wready two cycles ahead of awready.
        send('{8'h57, 8'h20, 8'h00, 8'h00, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11}, "ooo");
        chk("ooo wdata", wdata, 32'h1122_3344);
        chk("ooo awaddr", awaddr, 32'h0000_0020);
        wready = 1'b1;
        @(negedge clk);
        wready = 1'b0;
        chk("ooo w first", 32'({awvalid, wvalid}), 32'b10);
        chk("ooo no B", 32'(bready), 32'd0);
        @(negedge clk);
        chk("ooo aw wait", 32'({awvalid, wvalid, bready}), 32'b100);
        awready = 1'b1;
        @(negedge clk);
        awready = 1'b0;
        chk("ooo aw done", 32'({awvalid, wvalid}), 32'b00);
        chk("ooo B", 32'(bready), 32'd1);
        bvalid = 1'b1; bresp = 2'd0;
        @(negedge clk);
        bvalid = 1'b0;
        chk("ooo resp", 32'({m_tvalid, m_tdata}), 32'h100);
        @(negedge clk);
        chk("ooo resp end", 32'(m_tvalid), 32'd0);

        // Read response with m_tready pattern 1-0-0-1 repeating.
        arready = 1'b1; m_tready = 1'b0;
        send('{8'h52, 8'h08, 8'h00, 8'h00, 8'h00}, "stall");
        @(negedge clk);
        arready = 1'b0;
        rvalid = 1'b1; rdata = 32'hA1B2_C3D4; rresp = 2'd0;
        @(negedge clk);
        rvalid = 1'b0;
        exp_b = '{8'h00, 8'hD4, 8'hC3, 8'hB2, 8'hA1};
        pat = 4'b1001;
        idx = 0;
        for (int c = 0; c < 40 && idx < 5; c++) begin
            prev_rdy = pat[3 - (c % 4)];
            m_tready = prev_rdy;
            chk("stall valid", 32'(m_tvalid), 32'd1);
            chk("stall byte", 32'(m_tdata), 32'(exp_b[idx]));
            @(negedge clk);
            if (prev_rdy) idx++;
        end
        chk("stall count", 32'(idx), 32'd5);
        chk("stall end", 32'(m_tvalid), 32'd0);
        m_tready = 1'b1;

        // Garbage byte is dropped silently.
        send('{8'h00}, "junk");
        chk("junk idle", 32'({s_tready, m_tvalid, awvalid, arvalid}), 32'b1000);
        zero_wait_write("wr_junk");

        // Reset mid-ADDR loses the partial frame.
        send('{8'h57, 8'h11, 8'h22}, "partial");
        rst_n = 1'b0;
        #1;
        chk("midrst valids", 32'({awvalid, wvalid, arvalid, bready, rready, m_tvalid}), 32'd0);
        chk("midrst awaddr", awaddr, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        zero_wait_write("wr_rst");

`ifdef AXI_UART_MASTER_TIMEOUT_EN
        // arready never comes: arvalid must hold for exactly TCY cycles.
        arready = 1'b0; m_tready = 1'b1;
        send('{8'h52, 8'h00, 8'h01, 8'h00, 8'h00}, "tmo");
        n = 0;
        for (int c = 0; c < 40 && arvalid; c++) begin
            n++;
            @(negedge clk);
        end
        chk("tmo arvalid cycles", 32'(n), 32'd16);
        exp_b = '{8'h04, 8'h00, 8'h00, 8'h00, 8'h00};
        for (int i = 0; i < 5; i++) begin
            chk("tmo byte valid", 32'(m_tvalid), 32'd1);
            chk("tmo byte", 32'(m_tdata), 32'(exp_b[i]));
            @(negedge clk);
        end
        chk("tmo end", 32'({m_tvalid, s_tready, arvalid, rready}), 32'b0100);
`else
        n = 0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
